// File: rtl/rsp_s2_prep_pkg.sv
// Shared definitions for the S2 prep sample packer: FSM state encoding and
// the lane-count derivation used to size the packing datapath.
package rsp_s2_prep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of samples packed into one FIFO word.
    function automatic int calc_lanes(input int word_width, input int sample_width);
        return word_width / sample_width;
    endfunction

    // Width of the lane index; a single-lane configuration still needs one bit.
    function automatic int lane_idx_width(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/rsp_s2_prep_sample_pack_if.sv
// Sample-stream and FIFO-write signals of the sample packer. The master side
// produces samples and FIFO status; the slave side is the packer itself.
interface rsp_s2_prep_sample_pack_if #(
    parameter int SAMPLE_WIDTH = 32,
    parameter int WORD_WIDTH   = 128
);

    logic [SAMPLE_WIDTH-1:0] i_sample;
    logic                    i_sample_valid;
    logic                    i_sample_last;
    logic                    o_sample_ready;
    logic                    fifo_afull;
    logic                    fifo_full;
    logic                    o_fifo_wr_en;
    logic [WORD_WIDTH-1:0]   o_fifo_din;

    modport master (
        output i_sample, i_sample_valid, i_sample_last, fifo_afull, fifo_full,
        input  o_sample_ready, o_fifo_wr_en, o_fifo_din
    );

    modport slave (
        input  i_sample, i_sample_valid, i_sample_last, fifo_afull, fifo_full,
        output o_sample_ready, o_fifo_wr_en, o_fifo_din
    );

endinterface

// File: rtl/rsp_s2_prep_sample_pack.sv
// Packs SAMPLE_WIDTH samples little-endian into WORD_WIDTH FIFO words, one
// frame per i_start, zero-filling a trailing partial word on i_sample_last.
module rsp_s2_prep_sample_pack
    import rsp_s2_prep_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 32,
    parameter int WORD_WIDTH   = 128,   // integer multiple of SAMPLE_WIDTH
    parameter int DATA_NUM     = 1024
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_start,
    rsp_s2_prep_sample_pack_if.slave  bus,
    output logic [$clog2(DATA_NUM):0] o_word_cnt,
    output logic                      o_frame_done,
    output logic                      o_overflow
);

    localparam int LANES  = calc_lanes(WORD_WIDTH, SAMPLE_WIDTH);
    localparam int LANE_W = lane_idx_width(LANES);
    localparam int CNT_W  = $clog2(DATA_NUM) + 1;

    localparam logic [LANE_W-1:0] LAST_LANE   = LANE_W'(LANES - 1);
    localparam logic [CNT_W-1:0]  FRAME_WORDS = CNT_W'(DATA_NUM);

    state_t                  state;
    logic [LANE_W-1:0]       lane_cnt;
    logic [WORD_WIDTH-1:0]   lane_buf;
    logic [WORD_WIDTH-1:0]   word_next;
    logic [CNT_W-1:0]        word_cnt_next;
    logic                    accept;
    logic                    word_done;
    logic                    frame_end;

    assign bus.o_sample_ready = (state == RUN) && !bus.fifo_afull;
    assign accept             = bus.i_sample_valid && bus.o_sample_ready;
    assign word_done          = accept && ((lane_cnt == LAST_LANE) || bus.i_sample_last);
    assign word_cnt_next      = o_word_cnt + CNT_W'(1);
    // A dropped word still counts, so the frame limit is judged on the count alone.
    assign frame_end          = bus.i_sample_last || (word_cnt_next == FRAME_WORDS);

    // Lane buffer with the current sample merged in; unfilled lanes stay zero
    // because the buffer is cleared after every write.
    always_comb begin
        // NOTE: default assignment first so no path through the block infers a latch.
        word_next = lane_buf;
        for (int k = 0; k < LANES; k++) begin
            if (lane_cnt == LANE_W'(k)) begin
                word_next[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] = bus.i_sample;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            lane_cnt         <= '0;
            // NOTE: the lane buffer is reset too, so a partial word from an
            // aborted frame can never leak into the next one.
            lane_buf         <= '0;
            bus.o_fifo_wr_en <= 1'b0;
            bus.o_fifo_din   <= '0;
            o_word_cnt       <= '0;
            o_frame_done     <= 1'b0;
            o_overflow       <= 1'b0;
        end else begin
            bus.o_fifo_wr_en <= 1'b0;
            o_frame_done     <= 1'b0;

            case (state)
                IDLE: begin
                    if (i_start) begin
                        state      <= RUN;
                        lane_cnt   <= '0;
                        lane_buf   <= '0;
                        o_word_cnt <= '0;
                        o_overflow <= 1'b0;
                    end
                end

                RUN: begin
                    if (word_done) begin
                        // A full FIFO drops the word but the frame still advances.
                        bus.o_fifo_wr_en <= !bus.fifo_full;
                        bus.o_fifo_din   <= word_next;
                        o_overflow       <= o_overflow || bus.fifo_full;
                        o_word_cnt       <= word_cnt_next;
                        lane_cnt         <= '0;
                        lane_buf         <= '0;
                        if (frame_end) begin
                            state <= DONE;
                        end
                    end else if (accept) begin
                        lane_buf <= word_next;
                        lane_cnt <= lane_cnt + LANE_W'(1);
                    end
                end

                DONE: begin
                    o_frame_done <= 1'b1;
                    state        <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rsp_s2_prep_sample_pack.sv
// Directed bench for the sample packer: a default-size instance for packing,
// flush, back-pressure, overflow and reset, plus a DATA_NUM=4 instance for the frame limit.
module tb_rsp_s2_prep_sample_pack;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic start4;
    logic [10:0] word_cnt;
    logic [2:0]  word_cnt4;
    logic frame_done, frame_done4;
    logic overflow, overflow4;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    rsp_s2_prep_sample_pack_if #(.SAMPLE_WIDTH(32), .WORD_WIDTH(128)) bus ();
    rsp_s2_prep_sample_pack_if #(.SAMPLE_WIDTH(32), .WORD_WIDTH(128)) bus4 ();

    rsp_s2_prep_sample_pack #(.SAMPLE_WIDTH(32), .WORD_WIDTH(128), .DATA_NUM(1024)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (start),
        .bus          (bus),
        .o_word_cnt   (word_cnt),
        .o_frame_done (frame_done),
        .o_overflow   (overflow)
    );

    rsp_s2_prep_sample_pack #(.SAMPLE_WIDTH(32), .WORD_WIDTH(128), .DATA_NUM(4)) dut4 (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (start4),
        .bus          (bus4),
        .o_word_cnt   (word_cnt4),
        .o_frame_done (frame_done4),
        .o_overflow   (overflow4)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start               = 1'b0;
        start4              = 1'b0;
        bus.i_sample        = '0;
        bus.i_sample_valid  = 1'b0;
        bus.i_sample_last   = 1'b0;
        bus.fifo_afull      = 1'b0;
        bus.fifo_full       = 1'b0;
        bus4.i_sample       = '0;
        bus4.i_sample_valid = 1'b0;
        bus4.i_sample_last  = 1'b0;
        bus4.fifo_afull     = 1'b0;
        bus4.fifo_full      = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic start_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Presents one sample to the default instance for one clock edge.
    task automatic put(input logic [31:0] s, input logic last);
        bus.i_sample       = s;
        bus.i_sample_valid = 1'b1;
        bus.i_sample_last  = last;
        tick();
    endtask

    task automatic drop_valid();
        bus.i_sample_valid = 1'b0;
        bus.i_sample_last  = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) tick();
        assert_cnt++;
        if (bus.o_fifo_wr_en !== 1'b0) begin
            fail_cnt++; $display("FAIL reset_wr_en: got %b expected 0", bus.o_fifo_wr_en);
        end
        assert_cnt++;
        if (bus.o_fifo_din !== 128'h0) begin
            fail_cnt++; $display("FAIL reset_din: got %h expected 0", bus.o_fifo_din);
        end
        assert_cnt++;
        if (word_cnt !== 11'd0) begin
            fail_cnt++; $display("FAIL reset_word_cnt: got %0d expected 0", word_cnt);
        end
        assert_cnt++;
        if (frame_done !== 1'b0 || overflow !== 1'b0) begin
            fail_cnt++; $display("FAIL reset_flags: got done=%b ovf=%b expected 0 0", frame_done, overflow);
        end
        assert_cnt++;
        if (bus.o_sample_ready !== 1'b0 || bus4.o_sample_ready !== 1'b0) begin
            fail_cnt++; $display("FAIL reset_ready: got %b/%b expected 0/0", bus.o_sample_ready, bus4.o_sample_ready);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_pack8();
        logic [127:0] exp_word [2];
        exp_word[0] = 128'h00000004_00000003_00000002_00000001;
        exp_word[1] = 128'h00000008_00000007_00000006_00000005;
        start_frame();
        for (int i = 0; i < 8; i++) begin
            start = (i == 4);   // must be ignored while running
            put(32'(i + 1), 1'b0);
            start = 1'b0;
            if (i == 3 || i == 7) begin
                assert_cnt++;
                if (bus.o_fifo_wr_en !== 1'b1 || bus.o_fifo_din !== exp_word[i/4]) begin
                    fail_cnt++;
                    $display("FAIL pack8_word%0d: got wr=%b din=%h expected wr=1 din=%h",
                             i / 4, bus.o_fifo_wr_en, bus.o_fifo_din, exp_word[i/4]);
                end
            end else begin
                assert_cnt++;
                if (bus.o_fifo_wr_en !== 1'b0) begin
                    fail_cnt++; $display("FAIL pack8_no_write_%0d: got wr=%b expected 0", i, bus.o_fifo_wr_en);
                end
            end
        end
        drop_valid();
        assert_cnt++;
        if (word_cnt !== 11'd2) begin
            fail_cnt++; $display("FAIL pack8_word_cnt: got %0d expected 2", word_cnt);
        end
        do_reset();
    endtask

    task automatic test_last_flush();
        start_frame();
        for (int i = 0; i < 6; i++) begin
            put(32'hA + 32'(i), i == 5);
            if (i == 3) begin
                assert_cnt++;
                if (bus.o_fifo_wr_en !== 1'b1 || bus.o_fifo_din !== 128'h0000000D_0000000C_0000000B_0000000A) begin
                    fail_cnt++; $display("FAIL flush_word0: got wr=%b din=%h expected wr=1 din=0000000d0000000c0000000b0000000a",
                                         bus.o_fifo_wr_en, bus.o_fifo_din);
                end
            end
            if (i == 4) begin
                assert_cnt++;
                if (bus.o_fifo_wr_en !== 1'b0) begin
                    fail_cnt++; $display("FAIL flush_no_write: got wr=%b expected 0", bus.o_fifo_wr_en);
                end
            end
        end
        assert_cnt++;
        if (bus.o_fifo_wr_en !== 1'b1 || bus.o_fifo_din !== 128'h00000000_00000000_0000000F_0000000E) begin
            fail_cnt++; $display("FAIL flush_partial: got wr=%b din=%h expected wr=1 din=00000000000000000000000f0000000e",
                                 bus.o_fifo_wr_en, bus.o_fifo_din);
        end
        assert_cnt++;
        if (word_cnt !== 11'd2) begin
            fail_cnt++; $display("FAIL flush_word_cnt: got %0d expected 2", word_cnt);
        end
        drop_valid();
        assert_cnt++;
        if (bus.o_sample_ready !== 1'b0 || frame_done !== 1'b0) begin
            fail_cnt++; $display("FAIL flush_after_write: got ready=%b done=%b expected 0 0", bus.o_sample_ready, frame_done);
        end
        tick();
        assert_cnt++;
        if (frame_done !== 1'b1 || bus.o_fifo_wr_en !== 1'b0) begin
            fail_cnt++; $display("FAIL flush_frame_done: got done=%b wr=%b expected 1 0", frame_done, bus.o_fifo_wr_en);
        end
        tick();
        assert_cnt++;
        if (frame_done !== 1'b0 || bus.o_sample_ready !== 1'b0) begin
            fail_cnt++; $display("FAIL flush_done_pulse: got done=%b ready=%b expected 0 0", frame_done, bus.o_sample_ready);
        end
    endtask

    task automatic test_afull();
        int bad = 0;
        start_frame();
        put(32'h1, 1'b0);
        put(32'h2, 1'b0);
        bus.fifo_afull     = 1'b1;
        bus.i_sample       = 32'h99;
        bus.i_sample_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (bus.o_sample_ready !== 1'b0) bad++;
            tick();
            if (bus.o_fifo_wr_en !== 1'b0) bad++;
        end
        assert_cnt++;
        if (bad != 0) begin
            fail_cnt++; $display("FAIL afull_stall: got %0d ready/write events expected 0", bad);
        end
        bus.fifo_afull = 1'b0;
        put(32'h3, 1'b0);
        assert_cnt++;
        if (bus.o_fifo_wr_en !== 1'b0) begin
            fail_cnt++; $display("FAIL afull_lane2: got wr=%b expected 0", bus.o_fifo_wr_en);
        end
        put(32'h4, 1'b0);
        assert_cnt++;
        if (bus.o_fifo_wr_en !== 1'b1 || bus.o_fifo_din !== 128'h00000004_00000003_00000002_00000001) begin
            fail_cnt++; $display("FAIL afull_resume: got wr=%b din=%h expected wr=1 din=00000004000000030000000200000001",
                                 bus.o_fifo_wr_en, bus.o_fifo_din);
        end
        put(32'h5, 1'b1);
        assert_cnt++;
        if (bus.o_fifo_wr_en !== 1'b1 || bus.o_fifo_din !== 128'h5) begin
            fail_cnt++; $display("FAIL afull_single_lane_flush: got wr=%b din=%h expected wr=1 din=5",
                                 bus.o_fifo_wr_en, bus.o_fifo_din);
        end
        drop_valid();
        repeat (2) tick();
    endtask

    task automatic test_overflow();
        start_frame();
        put(32'h1, 1'b0);
        put(32'h2, 1'b0);
        put(32'h3, 1'b0);
        bus.fifo_full = 1'b1;
        put(32'h4, 1'b0);
        drop_valid();
        assert_cnt++;
        if (bus.o_fifo_wr_en !== 1'b0 || overflow !== 1'b1 || word_cnt !== 11'd1) begin
            fail_cnt++; $display("FAIL ovf_drop: got wr=%b ovf=%b cnt=%0d expected 0 1 1",
                                 bus.o_fifo_wr_en, overflow, word_cnt);
        end
        tick();
        bus.fifo_full = 1'b0;
        assert_cnt++;
        if (bus.o_fifo_wr_en !== 1'b0) begin
            fail_cnt++; $display("FAIL ovf_late_write: got wr=%b expected 0", bus.o_fifo_wr_en);
        end
        for (int i = 5; i <= 8; i++) put(32'(i), i == 8);
        drop_valid();
        assert_cnt++;
        if (bus.o_fifo_wr_en !== 1'b1 || bus.o_fifo_din !== 128'h00000008_00000007_00000006_00000005 ||
            word_cnt !== 11'd2) begin
            fail_cnt++; $display("FAIL ovf_next_word: got wr=%b din=%h cnt=%0d expected 1 00000008000000070000000600000005 2",
                                 bus.o_fifo_wr_en, bus.o_fifo_din, word_cnt);
        end
        tick();
        assert_cnt++;
        if (frame_done !== 1'b1 || overflow !== 1'b1) begin
            fail_cnt++; $display("FAIL ovf_sticky: got done=%b ovf=%b expected 1 1", frame_done, overflow);
        end
        tick();
        start_frame();
        assert_cnt++;
        if (overflow !== 1'b0 || word_cnt !== 11'd0) begin
            fail_cnt++; $display("FAIL ovf_clear_on_start: got ovf=%b cnt=%0d expected 0 0", overflow, word_cnt);
        end
        do_reset();
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        start_frame();
        put(32'h1, 1'b0);
        put(32'h2, 1'b0);
        put(32'h3, 1'b0);
        drop_valid();
        rst_n = 1'b0;
        #1;
        assert_cnt++;
        if (bus.o_fifo_wr_en !== 1'b0 || bus.o_fifo_din !== 128'h0 || word_cnt !== 11'd0 ||
            bus.o_sample_ready !== 1'b0 || frame_done !== 1'b0 || overflow !== 1'b0) begin
            fail_cnt++; $display("FAIL rstmid_outputs: got wr=%b din=%h cnt=%0d rdy=%b done=%b ovf=%b expected all 0",
                                 bus.o_fifo_wr_en, bus.o_fifo_din, word_cnt, bus.o_sample_ready, frame_done, overflow);
        end
        repeat (2) begin
            tick();
            if (bus.o_fifo_wr_en !== 1'b0) bad++;
        end
        rst_n = 1'b1;
        tick();
        if (bus.o_fifo_wr_en !== 1'b0 || bus.o_sample_ready !== 1'b0) bad++;
        assert_cnt++;
        if (bad != 0) begin
            fail_cnt++; $display("FAIL rstmid_no_write: got %0d write/ready events expected 0", bad);
        end
        start_frame();
        for (int i = 0; i < 4; i++) put(32'h11 + 32'(i), 1'b0);
        drop_valid();
        assert_cnt++;
        if (bus.o_fifo_wr_en !== 1'b1 || bus.o_fifo_din !== 128'h00000014_00000013_00000012_00000011) begin
            fail_cnt++; $display("FAIL rstmid_new_frame: got wr=%b din=%h expected wr=1 din=00000014000000130000001200000011",
                                 bus.o_fifo_wr_en, bus.o_fifo_din);
        end
        do_reset();
    endtask

    task automatic test_frame_limit();
        int writes = 0;
        int dones  = 0;
        logic ready_after = 1'b1;
        logic [127:0] fourth_din = '0;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int i = 0; i < 23; i++) begin
            bus4.i_sample       = 32'(i + 1);
            bus4.i_sample_valid = (i < 20);
            tick();
            if (bus4.o_fifo_wr_en === 1'b1) begin
                writes++;
                if (writes == 4) begin
                    fourth_din  = bus4.o_fifo_din;
                    ready_after = bus4.o_sample_ready;
                end
            end
            if (frame_done4 === 1'b1) dones++;
        end
        bus4.i_sample_valid = 1'b0;
        assert_cnt++;
        if (writes != 4) begin
            fail_cnt++; $display("FAIL limit_writes: got %0d expected 4", writes);
        end
        assert_cnt++;
        if (dones != 1) begin
            fail_cnt++; $display("FAIL limit_frame_done: got %0d pulses expected 1", dones);
        end
        assert_cnt++;
        if (ready_after !== 1'b0) begin
            fail_cnt++; $display("FAIL limit_ready: got %b expected 0", ready_after);
        end
        assert_cnt++;
        if (fourth_din !== 128'h00000010_0000000F_0000000E_0000000D || word_cnt4 !== 3'd4) begin
            fail_cnt++; $display("FAIL limit_last_word: got din=%h cnt=%0d expected 000000100000000f0000000e0000000d 4",
                                 fourth_din, word_cnt4);
        end
    endtask

    initial begin
        test_reset();
        test_pack8();
        test_last_flush();
        test_afull();
        test_overflow();
        test_reset_mid();
        test_frame_limit();
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
